// File: rtl/lvt_multiport_ram.sv
// Multi-port RAM: NW x NR banks of 1W/1R storage steered by a flip-flop live-value table.
// Latency: writes visible to reads issued on the next cycle; read data one cycle after rd_en.
// Backpressure: none; every write and read port accepts a request every cycle.
//
// Ports:
//   clk, rst_n          single rising-edge clock, asynchronous active-low reset
//   wr_en/addr/data[NW] one write request per write port; highest port index wins a collision
//   rd_en/addr[NR]      one read request per read port
//   rd_data[NR]         registered read data, holds while rd_en is low, 0 after reset
//   rd_valid[NR]        rd_en delayed by one cycle
//
// Each write port owns one bank per read port, so a read port only ever reads its own
// column of banks. The LVT says which write port's bank holds the live value for an
// address; the written flag masks banks that were never filled since reset, which lets
// the banks themselves stay un-reset.

module lvt_multiport_ram #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 64,
    parameter int NW     = 2,
    parameter int NR     = 4,
    parameter int BYPASS = 0,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NW-1:0]    wr_en,
    input  logic [AW-1:0]    wr_addr [NW],
    input  logic [WIDTH-1:0] wr_data [NW],
    input  logic [NR-1:0]    rd_en,
    input  logic [AW-1:0]    rd_addr [NR],
    output logic [WIDTH-1:0] rd_data [NR],
    output logic [NR-1:0]    rd_valid
);

    // One extra bit so the compare also works when DEPTH is a power of two.
    localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_LIM;
    endfunction

    // ------------------------------------------------------------------
    // Write qualification: addresses beyond DEPTH are dropped outright.
    // ------------------------------------------------------------------
    logic [NW-1:0] wr_ok;

    always_comb begin
        wr_ok = '0;
        for (int w = 0; w < NW; w++) begin
            wr_ok[w] = wr_en[w] && in_range(wr_addr[w]);
        end
    end

    // ------------------------------------------------------------------
    // Banks: bank[w][r] is written by write port w and read by read port r.
    // Combinational read at rd_addr[r]; the result is captured in rd_data.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] bank_rd [NW][NR];

    for (genvar gw = 0; gw < NW; gw++) begin : g_wr
        for (genvar gr = 0; gr < NR; gr++) begin : g_rd
            logic [WIDTH-1:0] mem [DEPTH];

            // Not reset: stale contents are hidden by the written flags.
            always_ff @(posedge clk) begin
                if (wr_ok[gw]) begin
                    mem[wr_addr[gw]] <= wr_data[gw];
                end
            end

            assign bank_rd[gw][gr] = mem[rd_addr[gr]];
        end
    end

    // ------------------------------------------------------------------
    // Live-value table and written flags.
    // Ports are visited in ascending order, so for a shared address the last
    // non-blocking assignment, from the highest port index, is the one kept.
    // ------------------------------------------------------------------
    logic [LW-1:0]    lvt [DEPTH];
    logic [DEPTH-1:0] written;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < DEPTH; d++) begin
                lvt[d] <= '0;
            end
            written <= '0;
        end else begin
            for (int w = 0; w < NW; w++) begin
                if (wr_ok[w]) begin
                    lvt[wr_addr[w]]     <= LW'(w);
                    written[wr_addr[w]] <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read selection.
    // Reading banks/LVT combinationally before the edge gives old-data
    // semantics for free; the forward path supplies new data when BYPASS=1.
    // ------------------------------------------------------------------
    logic [NR-1:0]    fwd_hit;
    logic [WIDTH-1:0] fwd_dat  [NR];
    logic [WIDTH-1:0] bank_sel [NR];
    logic [WIDTH-1:0] rd_next  [NR];

    always_comb begin
        fwd_hit = '0;
        for (int r = 0; r < NR; r++) begin
            fwd_dat[r]  = '0;
            bank_sel[r] = '0;
            rd_next[r]  = '0;
        end

        for (int r = 0; r < NR; r++) begin
            // Winning write to this read address on the current edge, if any.
            for (int w = 0; w < NW; w++) begin
                if (wr_ok[w] && (wr_addr[w] == rd_addr[r])) begin
                    fwd_hit[r] = 1'b1;
                    fwd_dat[r] = wr_data[w];
                end
            end

            // Bank of the write port that last wrote this address.
            for (int w = 0; w < NW; w++) begin
                if (lvt[rd_addr[r]] == LW'(w)) begin
                    bank_sel[r] = bank_rd[w][r];
                end
            end

            if (!in_range(rd_addr[r])) begin
                rd_next[r] = '0;
            end else if ((BYPASS != 0) && fwd_hit[r]) begin
                rd_next[r] = fwd_dat[r];
            end else if (written[rd_addr[r]]) begin
                rd_next[r] = bank_sel[r];
            end else begin
                rd_next[r] = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers. Reset drops any read in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= '0;
            for (int r = 0; r < NR; r++) begin
                rd_data[r] <= '0;
            end
        end else begin
            rd_valid <= rd_en;
            for (int r = 0; r < NR; r++) begin
                if (rd_en[r]) begin
                    rd_data[r] <= rd_next[r];
                end
            end
        end
    end

endmodule

// File: doc/lvt_multiport_ram.md
# lvt_multiport_ram

Parametrised multi-port RAM with independent write and read port counts. It is built from 1-write/1-read banks plus a flip-flop live-value table (LVT). The LVT records, per address, which write port last wrote it. Each read port uses that entry to select the bank holding the current value. It is the general register-file/scratchpad primitive for the memory subsystem: separate NW/NR counts, resettable contents tracking, selectable read-during-write behaviour and registered read outputs.

## Interface
- WIDTH, 32, data word width in bits.
- DEPTH, 64, number of words; ≥2. Address width AW = $clog2(DEPTH).
- NW, 2, number of write ports; ≥1.
- NR, 4, number of read ports; ≥1.
- BYPASS, 0, read-during-write mode: 0 = old data, 1 = new data.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en[NW]  input  1 each  write strobe per write port.
- wr_addr[NW]  input  AW each  write address.
- wr_data[NW]  input  WIDTH each  write data.
- rd_en[NR]  input  1 each  read strobe per read port.
- rd_addr[NR]  input  AW each  read address.
- rd_data[NR]  output  WIDTH each  registered read data.
- rd_valid[NR]  output  1 each  high for one cycle when rd_data carries a new result.

## Operation
- Storage is NW×NR banks. Bank[w][r] is written only by write port w and read only by read port r, so every write port's data is replicated to all NR read ports.
- The LVT is a DEPTH-entry array. Each entry is LW = max(1,$clog2(NW)) bits wide and sits beside a 1-bit written flag, also DEPTH entries. Both are flip-flops, so both are resettable.
- Write, when wr_en[w] is high at an edge:
  - Bank[w][*][wr_addr[w]] <= wr_data[w].
  - LVT[wr_addr[w]] <= w.
  - written[wr_addr[w]] <= 1.
- Write collision: if two or more enabled write ports share an address in one cycle, the highest port index wins. Its index goes into the LVT. The losers' bank writes still occur but are never selected.
- Read, when rd_en[r] is high at an edge: the address, the LVT entry and the written flag are sampled. The next cycle presents:
  - Bank[LVT][r] data when written=1.
  - All-zeros when written=0, i.e. the address has not been written since reset.
- Read-during-write, same edge, same address:
  - BYPASS=0: the returned data is the value before that edge.
  - BYPASS=1: the returned data is the winning write's wr_data, forwarded through the output register.
- Banks are not reset. Their contents are masked by the written flag after reset.
- The block never stalls or backpressures. Every port accepts every cycle.

## Timing
- Write latency: visible to a read issued on the following cycle (1 edge).
- Read latency: 1 cycle. rd_en at edge T gives rd_data/rd_valid at T+1.
- Back-to-back reads every cycle are supported on every port.
- rd_valid[r] is the registered rd_en[r].
- rd_data[r] holds its last value while rd_en[r] is low.
- Reset values:
  - rd_data = 0 and rd_valid = 0 on all ports.
  - All LVT entries = 0.
  - All written flags = 0.
- Reset asserted mid-operation:
  - Outputs clear immediately (asynchronously).
  - Any read in flight is dropped, with no rd_valid.
  - Writes on the reset edge are discarded.
  - After release, every address reads as 0 until rewritten.
- Wrap-around: addresses ≥ DEPTH (non-power-of-two DEPTH) are ignored on write and read as 0 with rd_valid=1.

## Test plan
- Reset then read all ports at addresses 0 and DEPTH-1 → rd_valid=1 at T+1, rd_data=0.
- Write port 0 writes 0xA5A5_0001 to addr 5 at T, then every read port reads addr 5 at T+1 → all rd_data=0xA5A5_0001 at T+2.
- Port 0 writes 0x1111 to addr 9 at T. At T+1, ports 0 and 1 both write addr 9 with 0x2222 and 0x3333. Reads of addr 9 at T+2 → 0x3333 (highest index wins); LVT[9]=1.
- Addr 3 holds 0x10. At T, write 0x20 to addr 3 and read addr 3 → BYPASS=0 returns 0x10 and BYPASS=1 returns 0x20 at T+1. A read at T+1 returns 0x20 in both modes.
- Write addr 7 = 0xBEEF, issue a read of addr 7, and assert rst_n low before the next edge → rd_valid stays 0. After release, a read of addr 7 returns 0.
- Random traffic on NW=3, NR=4, DEPTH=37 compared against a reference model with highest-index-wins collisions → zero mismatches over 10k cycles.
